// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a downstream 4:1 mux through channels 0..3, holding
// each select for SETTLE+1 cycles and sampling mux_out on the last one.
// The completed 4-bit word is published on data with a one-cycle valid.
// Optional build macro MUX_SCAN_CONT_EN adds the cont port; while cont is
// high, DONE restarts a scan directly instead of returning to IDLE.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mux_out,
`ifdef MUX_SCAN_CONT_EN
  input  logic       cont,
`endif
  output logic       s1,
  output logic       s0,
  output logic [3:0] data,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state;
  logic [1:0] ch;
  logic [3:0] cnt;
  logic [3:0] shadow;
  logic       rescan;

  // back-to-back scan request; tied off when the continuous mode is not built
`ifdef MUX_SCAN_CONT_EN
  assign rescan = cont;
`else
  assign rescan = 1'b0;
`endif

  // scan FSM; selects, busy, valid and data are all registered here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ch     <= 2'd0;
      cnt    <= 4'd0;
      shadow <= 4'd0;
      data   <= 4'd0;
      s1     <= 1'b0;
      s0     <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            state      <= SCAN;
            ch         <= 2'd0;
            cnt        <= SETTLE_C;
            {s1, s0}   <= 2'b00;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            shadow[ch] <= mux_out;
            if (ch == 2'd3) begin
              // shadow[3] is written this same edge, so take it from mux_out
              state    <= DONE;
              data     <= {mux_out, shadow[2:0]};
              valid    <= 1'b1;
              {s1, s0} <= 2'b00;
            end else begin
              ch       <= ch + 2'd1;
              cnt      <= SETTLE_C;
              {s1, s0} <= ch + 2'd1;
            end
          end
        end
        DONE: begin
          valid <= 1'b0;
          if (rescan) begin
            state    <= SCAN;
            ch       <= 2'd0;
            cnt      <= SETTLE_C;
            {s1, s0} <= 2'b00;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=0) share one stimulus
// stream; each is compared every cycle against a timeline model that derives
// select, busy, valid and data from the cycle offset into the scan.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       cont;
  logic [3:0] inp;

  logic       s1w [2];
  logic       s0w [2];
  logic       vw  [2];
  logic       bw  [2];
  logic       mw  [2];
  logic [3:0] dw  [2];

  int checks = 0;
  int errors = 0;

  // model state per instance
  int         sv  [2] = '{1, 0};
  bit         act [2];
  bit         dn  [2];
  int         k   [2];
  logic [3:0] samp[2];
  logic [3:0] ed  [2];
  int         vcnt[2];

  always #5 clock = ~clock;

  // downstream 4:1 mux driven by each instance's selects
  assign mw[0] = inp[{s1w[0], s0w[0]}];
  assign mw[1] = inp[{s1w[1], s0w[1]}];

  mux_scan_ctrl #(.SETTLE(1)) u0 (
    .clock(clock), .reset(reset), .start(start), .mux_out(mw[0]),
`ifdef MUX_SCAN_CONT_EN
    .cont(cont),
`endif
    .s1(s1w[0]), .s0(s0w[0]), .data(dw[0]), .valid(vw[0]), .busy(bw[0])
  );

  mux_scan_ctrl #(.SETTLE(0)) u1 (
    .clock(clock), .reset(reset), .start(start), .mux_out(mw[1]),
`ifdef MUX_SCAN_CONT_EN
    .cont(cont),
`endif
    .s1(s1w[1]), .s0(s0w[1]), .data(dw[1]), .valid(vw[1]), .busy(bw[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; dn[d] = 0; k[d] = 0; samp[d] = '0; ed[d] = '0;
    end
  endtask

  // what each instance should do at the coming rising edge
  task automatic model_next();
    if (reset) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      int per = sv[d] + 1;
      if (act[d]) begin
        int c = (k[d] - 1) / per;
        if (k[d] % per == 0) samp[d][c] = inp[c];
        if (k[d] == 4 * per) begin
          act[d] = 0; dn[d] = 1; ed[d] = samp[d];
        end else begin
          k[d]++;
        end
      end else if (dn[d]) begin
        dn[d] = 0;
        if (CONT_EN && cont) begin act[d] = 1; k[d] = 1; end
      end else if (start) begin
        act[d] = 1; k[d] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int esel = act[d] ? (k[d] - 1) / (sv[d] + 1) : 0;
      chk($sformatf("u%0d.sel", d), {30'd0, s1w[d], s0w[d]}, esel);
      chk($sformatf("u%0d.busy", d), bw[d], act[d] | dn[d]);
      chk($sformatf("u%0d.valid", d), vw[d], dn[d]);
      chk($sformatf("u%0d.data", d), dw[d], ed[d]);
      if (vw[d]) vcnt[d]++;
    end
  endtask

  task automatic cycle();
    model_next();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // reset asserted between edges; outputs must clear without a clock edge
  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    @(negedge clock);
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cont = 1'b0; inp = 4'b0000;
    model_clear();
    vcnt = '{0, 0};
    @(negedge clock);
    @(negedge clock);
    check_all();
    reset = 1'b0;
    cycle();

    // IN0..IN3 = 1,0,1,0
    inp = 4'b0101;
    pulse_start();
    run(10);
    chk("u0.data_0101", dw[0], 4'b0101);
    chk("u1.data_0101", dw[1], 4'b0101);

    // IN0..IN3 = 0,1,1,0
    inp = 4'b0110;
    pulse_start();
    run(10);
    chk("u0.data_0110", dw[0], 4'b0110);
    chk("u1.data_0110", dw[1], 4'b0110);

    // repeated start 3 cycles into a scan is neither honoured nor queued
    inp = 4'b1001;
    vcnt = '{0, 0};
    pulse_start();
    run(2);
    pulse_start();
    run(12);
    chk("u0.one_valid", vcnt[0], 1);
    chk("u0.data_1001", dw[0], 4'b1001);

    // reset 3 cycles after start: no valid, data cleared until next scan
    inp = 4'b1111;
    vcnt = '{0, 0};
    pulse_start();
    run(2);
    async_reset();
    run(12);
    chk("u0.no_valid_after_rst", vcnt[0], 0);
    chk("u0.data_cleared", dw[0], 4'b0000);

    // start present in the first cycle after reset release
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(10);
    chk("u0.data_1111", dw[0], 4'b1111);

    // input changed after its channel was sampled keeps the old value
    inp = 4'b0101;
    pulse_start();
    run(2);
    inp[0] = 1'b0;
    run(10);
    chk("u0.data_pre_change", dw[0], 4'b0101);
    chk("u1.data_pre_change", dw[1], 4'b0101);

`ifdef MUX_SCAN_CONT_EN
    // continuous scan: one valid every 9 cycles on u0, busy never drops
    cont = 1'b1;
    inp = 4'b0011;
    vcnt = '{0, 0};
    pulse_start();
    run(35);
    chk("u0.cont_pulses", vcnt[0], 4);
    cont = 1'b0;
    run(12);
`endif

    // randomized traffic including mid-scan resets
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(3) == 0);
      cont  = ($urandom_range(1) == 0);
      if ($urandom_range(5) == 0) inp = 4'($urandom);
      if ($urandom_range(79) == 0) async_reset();
      else cycle();
    end
    start = 1'b0;
    cont  = 1'b0;
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
